// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg: shared states and matrix geometry for the keypad scanner.
// Revision: 1.0
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } keypad_state_t;

  localparam int         ROWS     = 4;
  localparam int         COLS     = 4;
  localparam logic [3:0] ROW_IDLE = 4'b1110;

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_col_sync.sv
`default_nettype none
// ============================================================================
// col_sync: two-flop synchronizer; idles at all ones (no column pulled low).
// Revision: 1.0
// ============================================================================
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner: 4x4 matrix scanner with debounced key code and press/release pulses.
// Revision: 1.0
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [COLS-1:0] colN,
  output logic [ROWS-1:0] rowN,
  output logic [3:0]      keyCode,
  output logic            keyPressPulse,
  output logic            keyReleasePulse,
  output logic            keyIsPressed
);

  localparam int          c_ROW_W   = $clog2(ROWS);
  localparam int          c_COL_W   = $clog2(COLS);
  localparam logic [15:0] c_DIV_MAX = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  c_DEB     = 4'(DEBOUNCE_SCANS);

  logic [COLS-1:0]    w_colS;
  logic [15:0]        r_divCnt;
  logic               w_tick;
  logic               w_anyLow;
  logic [c_COL_W-1:0] w_winCol;

  keypad_state_t      r_state;
  keypad_state_t      w_stateNxt;
  logic [3:0]         r_debCnt;
  logic [3:0]         w_debCntNxt;
  logic [3:0]         w_debCntInc;
  logic [c_COL_W-1:0] r_candCol;
  logic [c_COL_W-1:0] w_candColNxt;
  logic [c_ROW_W-1:0] r_rowIdx;
  logic [c_ROW_W-1:0] w_rowIdxNxt;
  logic [c_ROW_W-1:0] w_rowIdxAdv;
  logic [ROWS-1:0]    r_rowN;
  logic [3:0]         r_keyCode;
  logic [3:0]         w_keyCodeNxt;
  logic               r_press;
  logic               w_pressNxt;
  logic               r_release;
  logic               w_releaseNxt;
  logic               r_pressed;
  logic               w_pressedNxt;

  col_sync #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk     (clk),
    .resetN  (resetN),
    .i_async (colN),
    .o_sync  (w_colS)
  );

  // Scan tick divider: one tick per row dwell.
  assign w_tick = (r_divCnt == c_DIV_MAX);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_divCnt <= '0;
    end else if (w_tick) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 16'd1;
    end
  end

  // Lowest-index low column wins.
  assign w_anyLow = ~&w_colS;

  always_comb begin
    w_winCol = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!w_colS[i]) begin
        w_winCol = c_COL_W'(i);
      end
    end
  end

  assign w_debCntInc = r_debCnt + 4'd1;
  assign w_rowIdxAdv = r_rowIdx + c_ROW_W'(1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  always_comb begin
    w_stateNxt   = r_state;
    w_debCntNxt  = r_debCnt;
    w_candColNxt = r_candCol;
    w_rowIdxNxt  = r_rowIdx;
    w_keyCodeNxt = r_keyCode;
    w_pressNxt   = 1'b0;
    w_releaseNxt = 1'b0;
    w_pressedNxt = r_pressed;

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_anyLow) begin
            w_candColNxt = w_winCol;
            w_debCntNxt  = 4'd1;
            if (c_DEB == 4'd1) begin
              w_keyCodeNxt = {r_rowIdx, w_winCol};
              w_pressNxt   = 1'b1;
              w_pressedNxt = 1'b1;
              w_debCntNxt  = 4'd0;
              w_stateNxt   = HELD;
            end else begin
              w_stateNxt = DEBOUNCE;
            end
          end else begin
            w_rowIdxNxt = w_rowIdxAdv;
          end
        end

        DEBOUNCE: begin
          if (w_anyLow && (w_winCol == r_candCol)) begin
            w_debCntNxt = w_debCntInc;
            if (w_debCntInc == c_DEB) begin
              w_keyCodeNxt = {r_rowIdx, r_candCol};
              w_pressNxt   = 1'b1;
              w_pressedNxt = 1'b1;
              w_debCntNxt  = 4'd0;
              w_stateNxt   = HELD;
            end
          end else begin
            // A bounce or a column change abandons the candidate entirely.
            w_debCntNxt = 4'd0;
            w_rowIdxNxt = w_rowIdxAdv;
            w_stateNxt  = SCAN;
          end
        end

        HELD: begin
          if (!w_anyLow) begin
            w_debCntNxt = 4'd1;
            if (c_DEB == 4'd1) begin
              w_releaseNxt = 1'b1;
              w_pressedNxt = 1'b0;
              w_debCntNxt  = 4'd0;
              w_rowIdxNxt  = w_rowIdxAdv;
              w_stateNxt   = SCAN;
            end else begin
              w_stateNxt = RELEASE;
            end
          end
        end

        RELEASE: begin
          if (!w_anyLow) begin
            w_debCntNxt = w_debCntInc;
            if (w_debCntInc == c_DEB) begin
              w_releaseNxt = 1'b1;
              w_pressedNxt = 1'b0;
              w_debCntNxt  = 4'd0;
              w_rowIdxNxt  = w_rowIdxAdv;
              w_stateNxt   = SCAN;
            end
          end else begin
            w_debCntNxt = 4'd0;
            w_stateNxt  = HELD;
          end
        end

        default: begin
          w_stateNxt = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_debCnt  <= '0;
      r_candCol <= '0;
      r_rowIdx  <= '0;
      r_rowN    <= ROW_IDLE;
      r_keyCode <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_debCnt  <= w_debCntNxt;
      r_candCol <= w_candColNxt;
      r_rowIdx  <= w_rowIdxNxt;
      r_rowN    <= ~(ROWS'(1) << w_rowIdxNxt);
      r_keyCode <= w_keyCodeNxt;
      r_press   <= w_pressNxt;
      r_release <= w_releaseNxt;
      r_pressed <= w_pressedNxt;
    end
  end

  assign rowN            = r_rowN;
  assign keyCode         = r_keyCode;
  assign keyPressPulse   = r_press;
  assign keyReleasePulse = r_release;
  assign keyIsPressed    = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner: directed checks of the keypad scanner with a pin-level keypad model.
// Revision: 1.0
// ============================================================================
module tb_keypad_scanner;

  logic        clk;
  logic        resetN;
  logic [3:0]  colN;
  logic [3:0]  rowN;
  logic [3:0]  keyCode;
  logic        keyPressPulse;
  logic        keyReleasePulse;
  logic        keyIsPressed;
  logic [15:0] keys;

  logic        resetN2;
  logic [3:0]  colN2;
  logic [3:0]  rowN2;
  logic [3:0]  keyCode2;
  logic        keyPressPulse2;
  logic        keyReleasePulse2;
  logic        keyIsPressed2;

  int cyc;
  int cyc2;
  int pressCnt;
  int relCnt;
  int lastPress;
  int lastRel;
  int pressCnt2;
  int relCnt2;
  int lastPress2;
  int lastRel2;
  int n_checks;
  int n_pass;

  keypad_scanner #(
    .SCAN_DIV       (16),
    .DEBOUNCE_SCANS (4)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .colN            (colN),
    .rowN            (rowN),
    .keyCode         (keyCode),
    .keyPressPulse   (keyPressPulse),
    .keyReleasePulse (keyReleasePulse),
    .keyIsPressed    (keyIsPressed)
  );

  keypad_scanner #(
    .SCAN_DIV       (2),
    .DEBOUNCE_SCANS (1)
  ) dut2 (
    .clk             (clk),
    .resetN          (resetN2),
    .colN            (colN2),
    .rowN            (rowN2),
    .keyCode         (keyCode2),
    .keyPressPulse   (keyPressPulse2),
    .keyReleasePulse (keyReleasePulse2),
    .keyIsPressed    (keyIsPressed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    colN = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !rowN[r]) colN[c] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(posedge clk or negedge resetN2) begin
    if (!resetN2) cyc2 <= 0;
    else          cyc2 <= cyc2 + 1;
  end

  always @(negedge clk) begin
    if (resetN) begin
      if (keyPressPulse)   begin pressCnt = pressCnt + 1; lastPress = cyc; end
      if (keyReleasePulse) begin relCnt = relCnt + 1;     lastRel = cyc;   end
    end
    if (resetN2) begin
      if (keyPressPulse2)   begin pressCnt2 = pressCnt2 + 1; lastPress2 = cyc2; end
      if (keyReleasePulse2) begin relCnt2 = relCnt2 + 1;     lastRel2 = cyc2;   end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc2(input int n);
    while (cyc2 < n) @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    pressCnt = 0; relCnt = 0; lastPress = -1; lastRel = -1;
    pressCnt2 = 0; relCnt2 = 0; lastPress2 = -1; lastRel2 = -1;
    keys = '0;
    colN2 = 4'b1111;
    resetN = 1'b0;
    resetN2 = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    chk("rst_rowN",    32'(rowN), 32'hE);
    chk("rst_keyCode", 32'(keyCode), 32'h0);
    chk("rst_press",   32'(keyPressPulse), 32'h0);
    chk("rst_release", 32'(keyReleasePulse), 32'h0);
    chk("rst_pressed", 32'(keyIsPressed), 32'h0);
    resetN = 1'b1;

    // Idle rotation, one row per 16 clocks.
    wait_cyc(1);  chk("rot_0",  32'(rowN), 32'hE);
    wait_cyc(15); chk("rot_15", 32'(rowN), 32'hE);
    wait_cyc(16); chk("rot_16", 32'(rowN), 32'hD);
    wait_cyc(32); chk("rot_32", 32'(rowN), 32'hB);
    wait_cyc(48); chk("rot_48", 32'(rowN), 32'h7);
    wait_cyc(64); chk("rot_64", 32'(rowN), 32'hE);

    // Key 6: first sampled by the tick on cycle 95, pulse on cycle 144.
    wait_cyc(66);  keys[6] = 1'b1;
    wait_cyc(150);
    chk("k6_pressCnt",  32'(pressCnt), 32'd1);
    chk("k6_pressCyc",  32'(lastPress), 32'd144);
    chk("k6_keyCode",   32'(keyCode), 32'd6);
    chk("k6_pressed",   32'(keyIsPressed), 32'h1);
    chk("k6_rowFrozen", 32'(rowN), 32'hD);
    // Release: first all-high tick on cycle 271, pulse on cycle 320.
    wait_cyc(266); keys[6] = 1'b0;
    wait_cyc(321);
    chk("k6_relCnt",    32'(relCnt), 32'd1);
    chk("k6_relCyc",    32'(lastRel), 32'd320);
    chk("k6_relPressed", 32'(keyIsPressed), 32'h0);
    chk("k6_relCode",   32'(keyCode), 32'd6);
    chk("k6_relRow",    32'(rowN), 32'hB);

    // Bounce on key 9: low at tick 335, high at tick 351.
    wait_cyc(322); keys[9] = 1'b1;
    wait_cyc(340); keys[9] = 1'b0;
    wait_cyc(352); chk("bnc_row3", 32'(rowN), 32'h7);
    wait_cyc(368); chk("bnc_row0", 32'(rowN), 32'hE);
    wait_cyc(380);
    chk("bnc_pressCnt", 32'(pressCnt), 32'd1);
    chk("bnc_keyCode",  32'(keyCode), 32'd6);

    // Keys 13 and 15 together: sampled at tick 431, pulse on cycle 480.
    keys[13] = 1'b1; keys[15] = 1'b1;
    wait_cyc(490);
    chk("two_pressCnt", 32'(pressCnt), 32'd2);
    chk("two_pressCyc", 32'(lastPress), 32'd480);
    chk("two_keyCode",  32'(keyCode), 32'd13);
    keys[12] = 1'b1;
    wait_cyc(600);
    chk("held_pressCnt", 32'(pressCnt), 32'd2);
    chk("held_keyCode",  32'(keyCode), 32'd13);
    chk("held_pressed",  32'(keyIsPressed), 32'h1);

    // Release glitch: high at ticks 607 and 623, low again at tick 639.
    keys[12] = 1'b0; keys[13] = 1'b0; keys[15] = 1'b0;
    wait_cyc(625); keys[13] = 1'b1;
    wait_cyc(650);
    chk("gl_relCnt",  32'(relCnt), 32'd1);
    chk("gl_pressed", 32'(keyIsPressed), 32'h1);
    chk("gl_pressCnt", 32'(pressCnt), 32'd2);
    wait_cyc(660); keys[13] = 1'b0;
    wait_cyc(721);
    chk("gl_relCnt2", 32'(relCnt), 32'd2);
    chk("gl_relCyc",  32'(lastRel), 32'd720);
    chk("gl_keyCode", 32'(keyCode), 32'd13);
    chk("gl_row",     32'(rowN), 32'hE);

    // Key 0 then reset while held.
    wait_cyc(722); keys[0] = 1'b1;
    wait_cyc(790);
    chk("k0_pressCnt", 32'(pressCnt), 32'd3);
    chk("k0_pressCyc", 32'(lastPress), 32'd784);
    chk("k0_keyCode",  32'(keyCode), 32'd0);
    wait_cyc(800);
    resetN = 1'b0;
    #1;
    chk("mr_pressed", 32'(keyIsPressed), 32'h0);
    chk("mr_rowN",    32'(rowN), 32'hE);
    @(negedge clk);
    #1;
    resetN = 1'b1;
    wait_cyc(70);
    chk("mr_relCnt",   32'(relCnt), 32'd2);
    chk("mr_pressCnt", 32'(pressCnt), 32'd4);
    chk("mr_pressCyc", 32'(lastPress), 32'd64);
    keys = '0;

    // SCAN_DIV = 2, DEBOUNCE_SCANS = 1: column held low independent of row.
    @(negedge clk);
    #1;
    chk("d2_rstRow", 32'(rowN2), 32'hE);
    resetN2 = 1'b1;
    wait_cyc2(10); colN2 = 4'b1011;
    wait_cyc2(12); chk("d2_notYet", 32'(keyIsPressed2), 32'h0);
    wait_cyc2(18);
    chk("d2_pressCnt", 32'(pressCnt2), 32'd1);
    chk("d2_pressCyc", 32'(lastPress2), 32'd14);
    chk("d2_keyCode",  32'(keyCode2), 32'd10);
    chk("d2_pressed",  32'(keyIsPressed2), 32'h1);
    wait_cyc2(20); colN2 = 4'b1111;
    wait_cyc2(28);
    chk("d2_relCnt",   32'(relCnt2), 32'd1);
    chk("d2_relCyc",   32'(lastRel2), 32'd24);
    chk("d2_relCode",  32'(keyCode2), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
